// File: rtl/multiplier.sv
// Iterative radix-2 shift-add multiplier, signed/unsigned, low or high product word.
// Optional MULTIPLIER_EARLY_TERMINATE_EN: stop iterating once the remaining multiplier bits are zero.
module multiplier #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             go,
  input  logic             muls,
  input  logic             high,
  output logic [WIDTH-1:0] c,
  output logic             is_zero,
  output logic             is_negative,
  output logic             available
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StRun, StFix, StDone} state_e;

  state_e                 state_q, state_d;
  logic [2*WIDTH-1:0]     acc_q, acc_d;
  logic [WIDTH-1:0]       mcand_q, mcand_d;
  logic [WIDTH-1:0]       mplier_q, mplier_d;
  logic [CntW-1:0]        count_q, count_d;
  logic                   sign_q, sign_d;
  logic                   high_q, high_d;
  logic [WIDTH-1:0]       c_q, c_d;
  logic                   zero_q, zero_d;
  logic                   neg_q, neg_d;
  logic                   available_q, available_d;

  logic [WIDTH-1:0]       a_abs, b_abs, mplier_shr, word_sel;
  logic [WIDTH:0]         sum;
  logic [2*WIDTH-1:0]     fix_val;
  logic                   last_iter;
  logic                   do_load;

  always_comb begin
    a_abs      = (muls && a[WIDTH-1]) ? -a : a;
    b_abs      = (muls && b[WIDTH-1]) ? -b : b;
    sum        = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
    mplier_shr = mplier_q >> 1;
    word_sel   = high_q ? acc_q[2*WIDTH-1:WIDTH] : acc_q[WIDTH-1:0];
`ifdef MULTIPLIER_EARLY_TERMINATE_EN
    last_iter  = (count_q == CntW'(WIDTH - 1)) || (mplier_shr == '0);
    // Finish the right shifts that the skipped iterations would have done.
    fix_val    = acc_q >> (CntW'(WIDTH) - count_q);
`else
    last_iter  = (count_q == CntW'(WIDTH - 1));
    fix_val    = acc_q;
`endif
    if (sign_q) begin
      fix_val = -fix_val;
    end
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    count_d     = count_q;
    sign_d      = sign_q;
    high_d      = high_q;
    c_d         = c_q;
    zero_d      = zero_q;
    neg_d       = neg_q;
    available_d = available_q;
    do_load     = 1'b0;

    unique case (state_q)
      StIdle: do_load = go;
      StRun: begin
        acc_d    = {sum, acc_q[WIDTH-1:1]};
        mplier_d = mplier_shr;
        count_d  = count_q + CntW'(1);
        if (last_iter) begin
          state_d = StFix;
        end
      end
      StFix: begin
        acc_d   = fix_val;
        state_d = StDone;
      end
      StDone: begin
        // First DONE cycle publishes the result; a go is honoured only once it is visible.
        if (!available_q) begin
          c_d         = word_sel;
          zero_d      = (word_sel == '0);
          neg_d       = word_sel[WIDTH-1];
          available_d = 1'b1;
        end else begin
          do_load = go;
        end
      end
      default: state_d = StIdle;
    endcase

    if (do_load) begin
      mcand_d     = a_abs;
      mplier_d    = b_abs;
      sign_d      = muls & (a[WIDTH-1] ^ b[WIDTH-1]);
      high_d      = high;
      acc_d       = '0;
      count_d     = '0;
      available_d = 1'b0;
      state_d     = StRun;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      count_q     <= '0;
      sign_q      <= 1'b0;
      high_q      <= 1'b0;
      c_q         <= '0;
      zero_q      <= 1'b0;
      neg_q       <= 1'b0;
      available_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      count_q     <= count_d;
      sign_q      <= sign_d;
      high_q      <= high_d;
      c_q         <= c_d;
      zero_q      <= zero_d;
      neg_q       <= neg_d;
      available_q <= available_d;
    end
  end

  assign c           = c_q;
  assign is_zero     = zero_q;
  assign is_negative = neg_q;
  assign available   = available_q;

endmodule

// File: doc/multiplier.md
Name: multiplier

Overview:
- Iterative shift-add integer multiplier; the multiply counterpart of the existing divider.
- Same operand/flag handshake as the divider: a, b, go in; c, is_zero, is_negative, available out.
- Lets the ALU issue MUL/MULH (signed and unsigned) through the same go/available protocol it already uses for DIV/REM.
- Radix-2, one multiplier bit per clock, 64-bit internal product; result word selected by the `high` input.

Parameters:
- WIDTH, 32, operand and result width; internal product 2*WIDTH bits.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- a  input  WIDTH  multiplicand.
- b  input  WIDTH  multiplier.
- go  input  1  start pulse, sampled on rising clk.
- muls  input  1  1 = operands two's-complement signed; 0 = unsigned.
- high  input  1  1 = return product[2W-1:W]; 0 = return product[W-1:0].
- c  output  WIDTH  selected product word, registered.
- is_zero  output  1  c == 0.
- is_negative  output  1  c[WIDTH-1].
- available  output  1  result valid.

Behaviour:
- Reset (reset=0, async): state=IDLE. c=0, is_zero=0, is_negative=0, available=0. Internal accumulator, counter and sign cleared.
- Reset mid-operation aborts the operation; no result is produced. After release the block waits for a new go.
- States: IDLE, RUN, FIX, DONE.
- IDLE/DONE with go=1 at edge E0 (LOAD):
  - Latch muls and high.
  - If muls, latch |a| and |b|; otherwise latch a and b.
  - sign = muls & (a[W-1] ^ b[W-1]).
  - acc = 0, count = 0, available <= 0.
  - Next state RUN.
- RUN, one edge per iteration:
  - If mplier[0]=1, add mcand to acc[2W-1:W] with a W+1-bit sum.
  - Shift {carry, acc} right 1; shift mplier right 1; count++.
  - After W iterations go to FIX.
- |x| of the most negative value (0x80000000) is 0x80000000 treated as unsigned. The product magnitude therefore fits in 2W bits.
- FIX (1 edge): if sign, product = two's-complement negate of the 2W-bit value. Next state DONE.
- DONE, registered at edge E0+W+2 (34 for W=32):
  - c = high ? product[2W-1:W] : product[W-1:0].
  - is_zero and is_negative computed from c.
  - available=1.
- Outputs hold in DONE until the next go.
- go during LOAD/RUN/FIX is ignored; the operation continues unchanged.
- go in DONE restarts: available drops at that same edge and c holds its old value until the new DONE.
- a, b, muls and high may change freely after E0; only E0 values are used.
- Unsigned results equal (a*b) mod 2^(2W), sliced. Signed results equal the 2W-bit two's-complement product, sliced.

Optional Feature:
- Macro: MULTIPLIER_EARLY_TERMINATE_EN.
- Defined:
  - RUN exits to FIX after any iteration that leaves the shifted mplier == 0. At least one iteration always runs.
  - The acc shift still totals W positions: the remaining right shift of (W - count) is applied in FIX before negation.
  - Latency = 2 + max(1, msb_index(|b|)+1) edges. Example: b=1 gives available at E0+3.
- Undefined: fixed latency W+2 for all operands.
- Results are identical in both builds.

Test Plan:
- Unsigned, muls=0: a=0xFFFFFFFF, b=0xFFFFFFFF.
  - high=0 -> c=0x00000001, is_zero=0, is_negative=0.
  - high=1 -> c=0xFFFFFFFE, is_negative=1.
- Signed, muls=1: a=0xFFFFFFFD (-3), b=7.
  - high=0 -> c=0xFFFFFFEB, is_negative=1.
  - high=1 -> c=0xFFFFFFFF.
- Signed, muls=1: a=b=0x80000000.
  - high=1 -> c=0x40000000.
  - high=0 -> c=0x00000000, is_zero=1.
- Timing, a=5, b=6, go pulse at E0:
  - available=0 through E0+33; available=1 with c=30 at E0+34 (feature off).
  - Extra go pulses at E0+5 and E0+20 do not change the timing or the result.
- Reset: assert reset=0 asynchronously at E0+10 -> all outputs 0 immediately. Release, no go for 50 cycles -> available stays 0.
- Randomized sweep of 10000 vectors per mode (muls x high): compare c/flags against a reference model. With MULTIPLIER_EARLY_TERMINATE_EN, b=1 -> available at E0+3 and b=0 -> available at E0+3 with c=0 and is_zero=1.
